// File: rtl/regfile_2r1w_if.sv
// Decode/writeback-facing bus of the 2-read/1-write integer register file.
interface regfile_2r1w_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned AW = 5;

  logic            rd_req;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            stall;
  logic            we;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rd_valid;

  modport master (
    output rd_req, rs1_addr, rs2_addr, stall, we, wr_addr, wr_data,
    input  rs1_data, rs2_data, rd_valid
  );

  modport slave (
    input  rd_req, rs1_addr, rs2_addr, stall, we, wr_addr, wr_data,
    output rs1_data, rs2_data, rd_valid
  );
endinterface

// File: rtl/regfile_2r1w.sv
// RV32I integer register file: x1..x31 in flops, x0 hardwired to zero,
// two registered read ports with stall hold, write bypass and held-operand refresh.

// 32:1 single-bit selector cell used to build every read-port bit.
module mux32t1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

module regfile_2r1w #(
  parameter int unsigned XLEN   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_2r1w_if.slave  bus
);
  localparam int unsigned AW   = 5;
  localparam int unsigned NREG = 32;

  logic [XLEN-1:0] mem_q [1:NREG-1];
  logic [XLEN-1:0] mem_d [1:NREG-1];
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [AW-1:0]   rs1_addr_q, rs1_addr_d;
  logic [AW-1:0]   rs2_addr_q, rs2_addr_d;
  logic            rd_valid_q, rd_valid_d;

  logic [XLEN-1:0] rs1_rd_c;
  logic [XLEN-1:0] rs2_rd_c;
  logic            wr_en_c;

  assign wr_en_c = bus.we && (bus.wr_addr != '0);

  // Per-bit column of the array (entry 0 is the constant-zero x0) feeding one mux per port.
  for (genvar b = 0; b < int'(XLEN); b++) begin : g_bit
    logic [NREG-1:0] col_c;

    always_comb begin
      col_c = '0;
      for (int r = 1; r < int'(NREG); r++) begin
        col_c[r] = mem_q[r][b];
      end
    end

    mux32t1 u_mux_rs1 (.d(col_c), .sel(bus.rs1_addr), .y(rs1_rd_c[b]));
    mux32t1 u_mux_rs2 (.d(col_c), .sel(bus.rs2_addr), .y(rs2_rd_c[b]));
  end

  always_comb begin
    mem_d = mem_q;
    if (wr_en_c) begin
      mem_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Capture / idle / stall-with-refresh selection for the output registers.
  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_valid_d = rd_valid_q;

    if (!bus.stall) begin
      if (bus.rd_req) begin
        rd_valid_d = 1'b1;
        rs1_addr_d = bus.rs1_addr;
        rs2_addr_d = bus.rs2_addr;
        rs1_data_d = (BYPASS && wr_en_c && (bus.wr_addr == bus.rs1_addr)) ? bus.wr_data : rs1_rd_c;
        rs2_data_d = (BYPASS && wr_en_c && (bus.wr_addr == bus.rs2_addr)) ? bus.wr_data : rs2_rd_c;
      end else begin
        rd_valid_d = 1'b0;
      end
    end else if (rd_valid_q && wr_en_c) begin
      if (bus.wr_addr == rs1_addr_q) rs1_data_d = bus.wr_data;
      if (bus.wr_addr == rs2_addr_q) rs2_data_d = bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < int'(NREG); r++) begin
        mem_q[r] <= '0;
      end
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rs1_data = rs1_data_q;
  assign bus.rs2_data = rs2_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed plus randomized bench for regfile_2r1w against an array-based operand model.
module tb_regfile_2r1w;
  localparam int unsigned XLEN   = 32;
  localparam bit          BYPASS = 1'b1;

  logic clk;
  logic rst_n;

  regfile_2r1w_if #(.XLEN(XLEN)) bus ();

  regfile_2r1w #(.XLEN(XLEN), .BYPASS(BYPASS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: architectural registers and what execute should currently see.
  logic [31:0] regs [32];
  logic [31:0] exp_rs1, exp_rs2;
  logic [4:0]  held_a1, held_a2;
  logic        exp_valid;

  int unsigned n_vec;
  int unsigned n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(bus.rd_valid), 32'(exp_valid));
    chk({tag, ".rs1"}, bus.rs1_data, exp_rs1);
    chk({tag, ".rs2"}, bus.rs2_data, exp_rs2);
  endtask

  function automatic logic [31:0] rd_reg(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    exp_rs1 = 32'd0; exp_rs2 = 32'd0;
    held_a1 = 5'd0;  held_a2 = 5'd0;
    exp_valid = 1'b0;
  endtask

  // One clock: drive at negedge, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic req, input logic [4:0] a1, input logic [4:0] a2,
                      input logic stl, input logic w, input logic [4:0] wa,
                      input logic [31:0] wd, input string tag);
    bit wr_ok;
    @(negedge clk);
    bus.rd_req = req; bus.rs1_addr = a1; bus.rs2_addr = a2;
    bus.stall = stl; bus.we = w; bus.wr_addr = wa; bus.wr_data = wd;
    @(posedge clk);
    wr_ok = w && (wa != 5'd0);
    if (!stl) begin
      if (req) begin
        exp_rs1 = (BYPASS && wr_ok && wa == a1) ? wd : rd_reg(a1);
        exp_rs2 = (BYPASS && wr_ok && wa == a2) ? wd : rd_reg(a2);
        held_a1 = a1; held_a2 = a2;
        exp_valid = 1'b1;
      end else begin
        exp_valid = 1'b0;
      end
    end else if (exp_valid && wr_ok) begin
      if (wa == held_a1) exp_rs1 = wd;
      if (wa == held_a2) exp_rs2 = wd;
    end
    if (wr_ok) regs[wa] = wd;
    #1;
    chk_all(tag);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, wa, wd, "write");
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
    step(1'b1, a1, a2, 1'b0, 1'b0, 5'd0, 32'd0, tag);
  endtask

  // Asynchronous reset asserted between edges, then released on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.we = 1'b0; bus.rd_req = 1'b0; bus.stall = 1'b0;
    model_reset();
    #1;
    chk_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    bus.rd_req = 1'b0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.stall = 1'b0; bus.we = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_reset();
    #12;
    chk_all("por");
    rst_n = 1'b1;

    // Dirty some state, then reset mid-run and confirm everything cleared.
    wr(5'd5, 32'hCAFE_F00D);
    rd(5'd5, 5'd5, "pre_reset");
    do_reset();
    rd(5'd5, 5'd0, "post_reset");
    chk("x5_cleared", bus.rs1_data, 32'd0);
    chk("x0_zero", bus.rs2_data, 32'd0);
    wr(5'd0, 32'hDEAD_BEEF);
    rd(5'd0, 5'd0, "x0_write_ignored");
    chk("x0_after_write", bus.rs1_data, 32'd0);

    // Basic write then read on both ports.
    wr(5'd7, 32'h1234_5678);
    rd(5'd7, 5'd7, "basic");
    chk("basic_rs1", bus.rs1_data, 32'h1234_5678);
    chk("basic_rs2", bus.rs2_data, 32'h1234_5678);

    // Same-cycle write/read forwarding; x0 writes never forward.
    wr(5'd3, 32'h11);
    step(1'b1, 5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 32'h22, "bypass");
    chk("bypass_rs1", bus.rs1_data, BYPASS ? 32'h22 : 32'h11);
    rd(5'd3, 5'd3, "bypass_after");
    chk("bypass_after_rs1", bus.rs1_data, 32'h22);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 32'h55, "bypass_x0");
    chk("bypass_x0_rs1", bus.rs1_data, 32'd0);

    // Stall holds operands; a write to a held address refreshes only that port.
    wr(5'd9, 32'hA);
    wr(5'd10, 32'hB);
    rd(5'd9, 5'd10, "stall_cap");
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 32'd0, "stall_c1");
    step(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 32'hC, "stall_c2");
    step(1'b0, 5'd4, 5'd6, 1'b1, 1'b0, 5'd0, 32'd0, "stall_c3");
    chk("refresh_rs1", bus.rs1_data, 32'hC);
    chk("refresh_rs2", bus.rs2_data, 32'hB);
    chk("refresh_valid", 32'(bus.rd_valid), 32'd1);

    // Valid follows rd_req with one cycle of lag.
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, "drop");
    chk("drop_valid", 32'(bus.rd_valid), 32'd0);
    rd(5'd7, 5'd9, "ilv1");
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, "ilv0");
    rd(5'd10, 5'd3, "ilv2");
    chk("ilv_valid", 32'(bus.rd_valid), 32'd1);

    // Full sweep of every register against a closed-form value.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h0101_0101);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i), "sweep");
      chk("sweep_rs1", bus.rs1_data, 32'(i) * 32'h0101_0101);
      chk("sweep_rs2", bus.rs2_data, 32'(31 - i) * 32'h0101_0101);
    end

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 3) == 0) ? held_a1 : 5'($urandom_range(0, 31)),
             $urandom, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Integer register file for the RV32I core: 32 x 32-bit architectural registers, two synchronous read ports (rs1/rs2), one write port (rd).
- Sits between decode (addresses in) and execute (operands out).
- Read selection is built per output bit from the codebase's mux32t1 cell: 32 instances per port, 64 total.
- Output registers carry a valid/stall handshake, same-cycle write bypass, and refresh of held operands during stall.

Parameters:
- XLEN, 32, data width; the read mux structure is fixed at 32 bits.
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = read returns the pre-write value.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_req  input  1  decode presents valid rs1_addr/rs2_addr this cycle.
- rs1_addr  input  5  read port 1 address.
- rs2_addr  input  5  read port 2 address.
- stall  input  1  execute cannot accept; hold outputs.
- we  input  1  write enable from writeback.
- wr_addr  input  5  write address.
- wr_data  input  XLEN  write data.
- rs1_data  output  XLEN  registered read data, port 1.
- rs2_data  output  XLEN  registered read data, port 2.
- rd_valid  output  1  rs1_data/rs2_data valid for execute.

Behaviour:
- Reset: the clock and reset are one clock, clk, and an asynchronous active-low reset, rst_n. While rst_n=0: x1..x31 = 0, rs1_data = rs2_data = 0, rd_valid = 0, latched addresses = 0. Reset mid-operation discards any pending read and write immediately; no write completes on the release edge unless we=1 at that edge.
- Storage: x1..x31 are flops. x0 is not stored and always reads 0. Writes with wr_addr=0 are ignored, including for bypass.
- Write: on a clk edge with we=1 and wr_addr!=0, mem[wr_addr] <= wr_data. Writes are independent of stall and rd_req.
- Read capture (stall=0, rd_req=1): at the edge, rsN_data <= selected value, rsN addresses latched, rd_valid <= 1. Latency is 1 cycle from address to data.
- Idle (stall=0, rd_req=0): rd_valid <= 0; rsN_data hold their last value (don't-care to the consumer).
- Stall (stall=1): rd_valid, rsN_data and latched addresses hold, except for refresh.
- Refresh: if stall=1, rd_valid=1, we=1, wr_addr!=0 and wr_addr equals a latched address, that port's data <= wr_data. Held operands therefore never go stale.
- Bypass (BYPASS=1): on capture, if we=1 and wr_addr==rsN_addr!=0, rsN_data <= wr_data, not the old mem value.
- No bypass (BYPASS=0): capture returns the old value; refresh still applies.
- Both ports may address the same register; each follows the rules independently.
- stall with rd_valid=0 has no effect other than holding state. rd_req is ignored while stall=1; decode must hold it.
- No combinational path from any input to any output.

Test Plan:
- Reset/x0: assert rst_n=0 mid-run, then release. Read x5 and x0 -> rs1_data=0, rs2_data=0, rd_valid=1 one cycle after rd_req. Then write x0=0xDEADBEEF, read x0 -> 0.
- Basic write/read: write x7=0x12345678. Next cycle rd_req with rs1=7, rs2=7 -> both 0x12345678 one cycle later.
- Bypass: x3=0x11. Same cycle, we x3=0x22 and rd_req rs1=3 -> rs1_data=0x22 (BYPASS=1) or 0x11 (BYPASS=0). x3 reads 0x22 afterwards in both cases.
- Stall/refresh: capture rs1=9 (0xA) and rs2=10 (0xB), then stall=1 for 3 cycles. Write x9=0xC in cycle 2 -> rs1_data becomes 0xC, rs2_data stays 0xB, rd_valid stays 1. Address changes during the stall are ignored.
- Valid drop: rd_req=0, stall=0 -> rd_valid=0 next cycle. Interleave rd_req 1,0,1 -> rd_valid follows with a 1-cycle lag.
- Sweep: write xi=i*0x01010101 for i=1..31, then read all pairs (i, 31-i) -> exact values, and 0 for x0.
